// File: rtl/motion_pkg.sv
// Shared definitions for the line segment sequencer: controller state
// encodings and the step-slot timing constants.
package motion_pkg;

    // Segment controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PLAY    = 2'd3
    } seq_state_e;

    // Shortest usable slot: one cycle for direction setup, one for the pulse.
    localparam int unsigned MIN_STEP_PERIOD   = 2;
    // Slot phase in which the point is examined and directions are set.
    localparam int unsigned SLOT_DIR_PHASE    = 0;
    // Slot phase in which step pulses fire and the position advances.
    localparam int unsigned SLOT_STEP_PHASE   = 1;
    // LOAD cycles to wait for the generator before re-strobing it once.
    localparam int unsigned LOAD_RETRY_CYCLES = 4;

endpackage

// File: rtl/seg_buf.sv
// Segment point buffer: simple dual-port RAM, one write port and one read
// port, registered read data (one-cycle latency), no reset on storage.
// Ports:
//   i_clk                 clock
//   i_wr_en/addr/data     write port
//   i_rd_en/addr          read request; data appears on o_rd_data next cycle
//   o_rd_data             read data, holds between reads
module seg_buf #(
    parameter int unsigned P_AW = 10,
    parameter int unsigned P_DW = 22
) (
    input  logic            i_clk,
    input  logic            i_wr_en,
    input  logic [P_AW-1:0] i_wr_addr,
    input  logic [P_DW-1:0] i_wr_data,
    input  logic            i_rd_en,
    input  logic [P_AW-1:0] i_rd_addr,
    output logic [P_DW-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 1 << P_AW;

    logic [P_DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/line_segment_sequencer.sv
// Line segment sequencer: accepts target points, has an external line
// generator rasterise the segment from the current position, buffers the
// points and plays them out as stepper step/direction pulses, one point per
// slot of i_step_period clocks.
// Ports:
//   i_clk, i_reset                     clock, synchronous active-high reset
//   i_tgt_x/y, i_tgt_valid, o_tgt_ready  target handshake (ready only in IDLE)
//   i_step_period                      clocks per played point (min 2)
//   o_lg_x0/y0/x1/y1, o_lg_load        segment request to the line generator
//   i_lg_x/y, i_lg_vals_rdy, i_lg_waiting  generator point stream / idle flag
//   o_x_step/dir, o_y_step/dir         stepper outputs (dir 1 = increasing)
//   o_pos_x/y                          position after issued steps
//   o_busy, o_err                      not-idle flag, rejected-segment pulse
module line_segment_sequencer
    import motion_pkg::*;
#(
    parameter int unsigned P_X_COORD_W = 11,
    parameter int unsigned P_Y_COORD_W = 11,
    parameter int unsigned P_BUF_AW    = 10,
    parameter int unsigned P_DIV_W     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [P_X_COORD_W-1:0] i_tgt_x,
    input  logic [P_Y_COORD_W-1:0] i_tgt_y,
    input  logic                   i_tgt_valid,
    output logic                   o_tgt_ready,
    input  logic [P_DIV_W-1:0]     i_step_period,
    output logic [P_X_COORD_W-1:0] o_lg_x0,
    output logic [P_X_COORD_W-1:0] o_lg_x1,
    output logic [P_Y_COORD_W-1:0] o_lg_y0,
    output logic [P_Y_COORD_W-1:0] o_lg_y1,
    output logic                   o_lg_load,
    input  logic [P_X_COORD_W-1:0] i_lg_x,
    input  logic [P_Y_COORD_W-1:0] i_lg_y,
    input  logic                   i_lg_vals_rdy,
    input  logic                   i_lg_waiting,
    output logic                   o_x_step,
    output logic                   o_x_dir,
    output logic                   o_y_step,
    output logic                   o_y_dir,
    output logic [P_X_COORD_W-1:0] o_pos_x,
    output logic [P_Y_COORD_W-1:0] o_pos_y,
    output logic                   o_busy,
    output logic                   o_err
);

    localparam int unsigned XW = P_X_COORD_W;
    localparam int unsigned YW = P_Y_COORD_W;
    localparam int unsigned CW = ((XW > YW) ? XW : YW) + 1;
    localparam int unsigned NW = (CW > P_BUF_AW + 1) ? CW : P_BUF_AW + 1;
    localparam int unsigned DW = XW + YW;
    localparam logic [NW-1:0] DEPTH = NW'(1) << P_BUF_AW;

    seq_state_e           state_q;
    logic [NW-1:0]        n_q;
    logic                 rev_q;
    logic [NW-1:0]        wr_cnt_q;
    logic [P_BUF_AW-1:0]  rd_ptr_q;
    logic [NW-1:0]        rem_q;
    logic [P_DIV_W-1:0]   ph_q;
    logic [P_DIV_W-1:0]   per_q;
    logic                 primed_q;
    logic [1:0]           load_cnt_q;
    logic                 reloaded_q;
    logic [XW-1:0]        pt_x_q;
    logic [YW-1:0]        pt_y_q;

    logic [CW-1:0]        tx_w, ty_w, px_w, py_w, dx_c, dy_c, major_c;
    logic [NW-1:0]        n_c;
    logic                 steep_c, rev_c, too_long_c;
    logic                 wr_en_c, wr_last_c, rd_en_c;
    logic [P_DIV_W-1:0]   period_c;
    logic [DW-1:0]        rd_data;
    logic [XW-1:0]        rd_x;
    logic [YW-1:0]        rd_y;

    // Segment geometry of the offered target against the current position.
    always_comb begin
        tx_w       = CW'(i_tgt_x);
        ty_w       = CW'(i_tgt_y);
        px_w       = CW'(o_pos_x);
        py_w       = CW'(o_pos_y);
        dx_c       = (tx_w >= px_w) ? (tx_w - px_w) : (px_w - tx_w);
        dy_c       = (ty_w >= py_w) ? (ty_w - py_w) : (py_w - ty_w);
        steep_c    = dy_c > dx_c;
        major_c    = steep_c ? dy_c : dx_c;
        n_c        = NW'(major_c) + NW'(1);
        // Generator emits along increasing major axis; play backwards if we travel down it.
        rev_c      = steep_c ? (py_w > ty_w) : (px_w > tx_w);
        too_long_c = n_c > DEPTH;
    end

    // Buffer write/read strobes and the effective slot period.
    always_comb begin
        wr_en_c   = ((state_q == ST_LOAD) || (state_q == ST_CAPTURE))
                    && i_lg_vals_rdy && (wr_cnt_q < n_q);
        wr_last_c = wr_en_c && ((wr_cnt_q + NW'(1)) == n_q);
        rd_en_c   = (state_q == ST_PLAY)
                    && (!primed_q || (ph_q == P_DIV_W'(SLOT_DIR_PHASE)));
        period_c  = (i_step_period < P_DIV_W'(MIN_STEP_PERIOD))
                    ? P_DIV_W'(MIN_STEP_PERIOD) : i_step_period;
    end

    assign rd_x = rd_data[DW-1:YW];
    assign rd_y = rd_data[YW-1:0];

    seg_buf #(
        .P_AW (P_BUF_AW),
        .P_DW (DW)
    ) u_seg_buf (
        .i_clk     (i_clk),
        .i_wr_en   (wr_en_c),
        .i_wr_addr (wr_cnt_q[P_BUF_AW-1:0]),
        .i_wr_data ({i_lg_x, i_lg_y}),
        .i_rd_en   (rd_en_c),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (rd_data)
    );

    // Segment controller with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            rev_q       <= 1'b0;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            ph_q        <= '0;
            per_q       <= '0;
            primed_q    <= 1'b0;
            load_cnt_q  <= '0;
            reloaded_q  <= 1'b0;
            pt_x_q      <= '0;
            pt_y_q      <= '0;
            o_tgt_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
            o_lg_load   <= 1'b0;
            o_lg_x0     <= '0;
            o_lg_x1     <= '0;
            o_lg_y0     <= '0;
            o_lg_y1     <= '0;
            o_x_step    <= 1'b0;
            o_y_step    <= 1'b0;
            o_x_dir     <= 1'b0;
            o_y_dir     <= 1'b0;
            o_pos_x     <= '0;
            o_pos_y     <= '0;
        end else begin
            o_lg_load <= 1'b0;
            o_err     <= 1'b0;
            o_x_step  <= 1'b0;
            o_y_step  <= 1'b0;

            if (wr_en_c) begin
                wr_cnt_q <= wr_cnt_q + NW'(1);
            end
            if (rd_en_c) begin
                rd_ptr_q <= rev_q ? (rd_ptr_q - P_BUF_AW'(1)) : (rd_ptr_q + P_BUF_AW'(1));
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_tgt_valid) begin
                        if (too_long_c) begin
                            o_err <= 1'b1;
                        end else begin
                            o_lg_x0     <= o_pos_x;
                            o_lg_y0     <= o_pos_y;
                            o_lg_x1     <= i_tgt_x;
                            o_lg_y1     <= i_tgt_y;
                            o_lg_load   <= 1'b1;
                            n_q         <= n_c;
                            rev_q       <= rev_c;
                            wr_cnt_q    <= '0;
                            load_cnt_q  <= '0;
                            reloaded_q  <= 1'b0;
                            o_tgt_ready <= 1'b0;
                            o_busy      <= 1'b1;
                            state_q     <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD, ST_CAPTURE: begin
                    if (wr_last_c) begin
                        if (n_q == NW'(1)) begin
                            // Zero-length segment: nothing to play.
                            o_tgt_ready <= 1'b1;
                            o_busy      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            // Start point (already our position) is skipped.
                            rd_ptr_q <= rev_q ? P_BUF_AW'(n_q - NW'(2)) : P_BUF_AW'(1);
                            rem_q    <= n_q - NW'(1);
                            primed_q <= 1'b0;
                            ph_q     <= '0;
                            state_q  <= ST_PLAY;
                        end
                    end else if (state_q == ST_LOAD) begin
                        if (!i_lg_waiting) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            load_cnt_q <= load_cnt_q + 2'd1;
                            if ((load_cnt_q == 2'(LOAD_RETRY_CYCLES - 1)) && !reloaded_q) begin
                                o_lg_load  <= 1'b1;
                                reloaded_q <= 1'b1;
                            end
                        end
                    end
                end

                ST_PLAY: begin
                    if (!primed_q) begin
                        // First read in flight; its data is ready for slot phase 0.
                        primed_q <= 1'b1;
                        ph_q     <= '0;
                    end else if (ph_q == P_DIV_W'(SLOT_DIR_PHASE)) begin
                        per_q  <= period_c;
                        pt_x_q <= rd_x;
                        pt_y_q <= rd_y;
                        if (rd_x != o_pos_x) begin
                            o_x_dir <= rd_x > o_pos_x;
                        end
                        if (rd_y != o_pos_y) begin
                            o_y_dir <= rd_y > o_pos_y;
                        end
                        ph_q <= ph_q + P_DIV_W'(1);
                    end else begin
                        if (ph_q == P_DIV_W'(SLOT_STEP_PHASE)) begin
                            o_x_step <= pt_x_q != o_pos_x;
                            o_y_step <= pt_y_q != o_pos_y;
                            o_pos_x  <= pt_x_q;
                            o_pos_y  <= pt_y_q;
                        end
                        if (ph_q == (per_q - P_DIV_W'(1))) begin
                            if (rem_q == NW'(1)) begin
                                o_tgt_ready <= 1'b1;
                                o_busy      <= 1'b0;
                                state_q     <= ST_IDLE;
                            end else begin
                                rem_q <= rem_q - NW'(1);
                                ph_q  <= '0;
                            end
                        end else begin
                            ph_q <= ph_q + P_DIV_W'(1);
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
